// File: rtl/hgdb_pkg.sv
// Shared types for the hgdb debug responder: command/response encodings and the
// response event record.
package hgdb_pkg;

    localparam int MAX_BP = 32;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_SET_BP   = 3'd1,
        OP_CLR_BP   = 3'd2,
        OP_CONTINUE = 3'd3,
        OP_STEP     = 3'd4,
        OP_HALT     = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        RSP_ACK       = 2'd0,
        RSP_HIT       = 2'd1,
        RSP_STEP_DONE = 2'd2,
        RSP_ERR       = 2'd3
    } rsp_t;

    typedef struct packed {
        rsp_t       code;
        logic [4:0] id;
    } evt_t;

endpackage

// File: rtl/hgdb_bp_match.sv
// Breakpoint matcher: masks raw breakpoint conditions and reports the lowest
// armed slot that fired.
module hgdb_bp_match
    import hgdb_pkg::*;
#(
    parameter int NUM_BP = 8
) (
    input  logic [NUM_BP-1:0]          bp_hit,
    input  logic [NUM_BP-1:0]          bp_mask,
    output logic                       any_hit,
    output logic [$clog2(MAX_BP)-1:0]  hit_id
);

    logic [NUM_BP-1:0] masked;

    assign masked  = bp_hit & bp_mask;
    assign any_hit = |masked;

    // Scan from the top so the lowest set index is written last and wins.
    always_comb begin
        hit_id = '0;
        for (int unsigned i = NUM_BP; i > 0; i--) begin
            if (masked[i-1]) hit_id = ($clog2(MAX_BP))'(i - 1);
        end
    end

endmodule

// File: rtl/hgdb_debug_responder.sv
// Debugger-facing run control: HALT/RUN/STEP with breakpoint halting and a
// registered response channel. Define HGDB_CYCLE_COUNT_EN to build the cycle counter.
module hgdb_debug_responder
    import hgdb_pkg::*;
#(
    parameter int NUM_BP = 8,
    parameter int CYC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [15:0]       cmd_arg,
    input  logic [NUM_BP-1:0] bp_hit,
    output logic              dut_en,
    output logic              halted,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_code,
    output logic [4:0]        rsp_id,
    output logic [CYC_W-1:0]  rsp_cycle
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    logic [1:0]        state, state_nx;
    logic [NUM_BP-1:0] bp_mask, mask_nx;
    logic [15:0]       step_cnt, step_nx;
    logic              any_hit, hit_now, cmd_acc, arg_ok, last_step;
    logic [4:0]        hit_id;

    logic              cmd_evt_v, core_evt_v;
    evt_t              cmd_evt, core_evt;
    logic              e0_v, e1_v;
    evt_t              e0;
    evt_t              out_evt, pend_evt;
    logic              pend_valid;
    logic              pop, take_pend, e0_to_out, e0_to_pend;

    hgdb_bp_match #(
        .NUM_BP (NUM_BP)
    ) u_match (
        .bp_hit  (bp_hit),
        .bp_mask (bp_mask),
        .any_hit (any_hit),
        .hit_id  (hit_id)
    );

    assign dut_en    = (state != ST_HALT);
    assign halted    = (state == ST_HALT);
    assign hit_now   = any_hit && dut_en;
    assign cmd_ready = !rsp_valid && !hit_now;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign arg_ok    = (cmd_arg < 16'(NUM_BP));
    assign last_step = (state == ST_STEP) && (step_cnt == 16'd1);

    always_comb begin
        state_nx   = state;
        mask_nx    = bp_mask;
        step_nx    = (state == ST_STEP) ? step_cnt - 16'd1 : step_cnt;
        cmd_evt_v  = 1'b0;
        cmd_evt    = '0;
        core_evt_v = 1'b0;
        core_evt   = '0;

        if (cmd_acc) begin
            case (cmd_op)
                OP_NOP: ;
                OP_SET_BP, OP_CLR_BP: begin
                    cmd_evt_v    = 1'b1;
                    cmd_evt.code = arg_ok ? RSP_ACK : RSP_ERR;
                    for (int unsigned i = 0; i < NUM_BP; i++) begin
                        if (cmd_arg == 16'(i)) mask_nx[i] = (cmd_op == OP_SET_BP);
                    end
                end
                OP_CONTINUE: begin
                    cmd_evt_v = 1'b1;
                    if (state == ST_HALT) state_nx = ST_RUN;
                    else                  cmd_evt.code = RSP_ERR;
                end
                // A valid STEP answers later with STEP_DONE or HIT, not now.
                OP_STEP: begin
                    if (state == ST_HALT && cmd_arg != 16'd0) begin
                        state_nx = ST_STEP;
                        step_nx  = cmd_arg;
                    end else begin
                        cmd_evt_v    = 1'b1;
                        cmd_evt.code = RSP_ERR;
                    end
                end
                OP_HALT: begin
                    cmd_evt_v = 1'b1;
                    state_nx  = ST_HALT;
                end
                default: begin
                    cmd_evt_v    = 1'b1;
                    cmd_evt.code = RSP_ERR;
                end
            endcase
        end

        // An explicit HALT landing on the last step cycle aborts the step silently.
        if (hit_now) begin
            core_evt_v    = 1'b1;
            core_evt.code = RSP_HIT;
            core_evt.id   = hit_id;
            state_nx      = ST_HALT;
        end else if (last_step && !(cmd_acc && cmd_op == OP_HALT)) begin
            core_evt_v    = 1'b1;
            core_evt.code = RSP_STEP_DONE;
            state_nx      = ST_HALT;
        end
    end

    // Output register plus one pending slot: a hit or step completion can arrive
    // while an earlier response is still held, and is queued behind it.
    assign e0_v       = cmd_evt_v || core_evt_v;
    assign e0         = cmd_evt_v ? cmd_evt : core_evt;
    assign e1_v       = cmd_evt_v && core_evt_v;
    assign pop        = rsp_valid && rsp_ready;
    assign take_pend  = pop && pend_valid;
    assign e0_to_out  = e0_v && (!rsp_valid || (pop && !pend_valid));
    assign e0_to_pend = e0_v && !e0_to_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HALT;
            bp_mask    <= '0;
            step_cnt   <= '0;
            rsp_valid  <= 1'b0;
            pend_valid <= 1'b0;
            out_evt    <= '0;
            pend_evt   <= '0;
        end else begin
            state      <= state_nx;
            bp_mask    <= mask_nx;
            step_cnt   <= step_nx;
            rsp_valid  <= (rsp_valid && !pop) || take_pend || e0_to_out;
            pend_valid <= (pend_valid && !take_pend) || e0_to_pend || e1_v;
            if (take_pend)      out_evt <= pend_evt;
            else if (e0_to_out) out_evt <= e0;
            if (e1_v)            pend_evt <= core_evt;
            else if (e0_to_pend) pend_evt <= e0;
        end
    end

    assign rsp_code = out_evt.code;
    assign rsp_id   = out_evt.id;

`ifdef HGDB_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_cnt, pend_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            pend_cyc  <= '0;
            rsp_cycle <= '0;
        end else begin
            if (dut_en) cyc_cnt <= cyc_cnt + CYC_W'(1);
            if (take_pend)      rsp_cycle <= pend_cyc;
            else if (e0_to_out) rsp_cycle <= cyc_cnt;
            if (e1_v || e0_to_pend) pend_cyc <= cyc_cnt;
        end
    end
`else
    assign rsp_cycle = '0;
`endif

endmodule

// File: tb/tb_hgdb_debug_responder.sv
// Scoreboard bench for hgdb_debug_responder: directed scenarios then random
// traffic, checked against a cycle-level behavioural model.
module tb_hgdb_debug_responder;
    import hgdb_pkg::*;

    localparam int NUM_BP = 8;
    localparam int CYC_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [15:0]       cmd_arg = '0;
    logic [NUM_BP-1:0] bp_hit = '0;
    logic              dut_en, halted, rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_code;
    logic [4:0]        rsp_id;
    logic [CYC_W-1:0]  rsp_cycle;

    always #5 clk = ~clk;

    hgdb_debug_responder #(
        .NUM_BP (NUM_BP),
        .CYC_W  (CYC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .bp_hit    (bp_hit),
        .dut_en    (dut_en),
        .halted    (halted),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_code  (rsp_code),
        .rsp_id    (rsp_id),
        .rsp_cycle (rsp_cycle)
    );

    typedef struct {
        logic [1:0]       code;
        logic [4:0]       id;
        logic [CYC_W-1:0] cyc;
    } exp_t;

    typedef enum {M_HALT, M_RUN, M_STEP} mst_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    mst_t        mstate = M_HALT;
    int          steps_left = 0;
    bit [NUM_BP-1:0] mmask = '0;
    int unsigned mcyc = 0;
    bit          last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CYC_W-1:0] cyc_exp();
`ifdef HGDB_CYCLE_COUNT_EN
        return CYC_W'(mcyc);
`else
        return '0;
`endif
    endfunction

    task automatic push(input logic [1:0] code, input int id);
        exp_t e;
        e.code = code;
        e.id   = 5'(id);
        e.cyc  = cyc_exp();
        sb.push_back(e);
    endtask

    // One clock of the reference model, evaluated after inputs are driven.
    task automatic model_eval(input bit v, input logic [2:0] op, input logic [15:0] arg,
                              input logic [NUM_BP-1:0] hit);
        bit en, h, exp_rdy, acc;
        bit [NUM_BP-1:0] m;
        mst_t nxt;
        int hid;
        en      = (mstate != M_HALT);
        m       = hit & mmask;
        h       = en && (m != 0);
        exp_rdy = (sb.size() == 0) && !h;
        nxt     = mstate;
        check("cmd_ready", cmd_ready, exp_rdy);
        check("dut_en", dut_en, en);
        check("halted", halted, mstate == M_HALT);
        acc = v && exp_rdy;
        last_acc = acc;
        if (acc) begin
            case (op)
                3'd0: ;
                3'd1, 3'd2: begin
                    if (arg < NUM_BP) begin
                        mmask[arg[2:0]] = (op == 3'd1);
                        push(RSP_ACK, 0);
                    end else push(RSP_ERR, 0);
                end
                3'd3: begin
                    if (mstate == M_HALT) begin nxt = M_RUN; push(RSP_ACK, 0); end
                    else push(RSP_ERR, 0);
                end
                3'd4: begin
                    if (mstate == M_HALT && arg > 0) begin nxt = M_STEP; steps_left = int'(arg); end
                    else push(RSP_ERR, 0);
                end
                3'd5: begin push(RSP_ACK, 0); nxt = M_HALT; end
                default: push(RSP_ERR, 0);
            endcase
        end
        if (h) begin
            hid = -1;
            for (int i = 0; i < NUM_BP; i++) if (m[i] && hid < 0) hid = i;
            push(RSP_HIT, hid);
            nxt = M_HALT;
        end else if (mstate == M_STEP && steps_left == 1 && !(acc && op == 3'd5)) begin
            push(RSP_STEP_DONE, 0);
            nxt = M_HALT;
        end
        if (mstate == M_STEP) steps_left--;
        if (en) mcyc++;
        mstate = nxt;
    endtask

    task automatic step_cycle(input bit v, input logic [2:0] op, input logic [15:0] arg,
                              input logic [NUM_BP-1:0] hit, input bit rdy);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_arg = arg; bp_hit = hit; rsp_ready = rdy;
        #1;
        model_eval(v, op, arg, hit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_cycle(0, 3'd0, 16'd0, '0, 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] arg);
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step_cycle(1, op, arg, '0, 1);
            ok = last_acc;
        end
        check("send_accept", ok, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; cmd_valid = 1'b0; bp_hit = '0; rsp_ready = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_halted", halted, 1);
        check("rst_dut_en", dut_en, 0);
        check("rst_rsp_code", rsp_code, RSP_ACK);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_cycle", rsp_cycle, 0);
        sb.delete();
        mstate = M_HALT; steps_left = 0; mmask = '0; mcyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    // Monitor: pops the scoreboard on each response handshake and checks hold stability.
    initial begin
        bit prev_hold = 0;
        logic [14:0] held = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_hold = 0;
                continue;
            end
            if (prev_hold) begin
                check("hold_valid", rsp_valid, 1);
                check("hold_fields", {rsp_code, rsp_id, rsp_cycle}, held);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got code %0d id %0d, expected none", rsp_code, rsp_id);
                end else begin
                    e = sb.pop_front();
                    check("rsp_code", rsp_code, e.code);
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_cycle", rsp_cycle, e.cyc);
                end
                prev_hold = 0;
            end else if (rsp_valid) begin
                prev_hold = 1;
                held = {rsp_code, rsp_id, rsp_cycle};
            end else prev_hold = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0]        op;
        logic [15:0]       arg;
        logic [NUM_BP-1:0] hit;

        apply_reset();

        // Breakpoint 3 fires on the 10th run cycle.
        send(OP_SET_BP, 16'd3);
        send(OP_CONTINUE, 16'd0);
        n = 0;
        while (mcyc != 9 && n < 50) begin idle(1); n++; end
        step_cycle(0, 3'd0, 16'd0, 8'h08, 1);
        idle(3);

        // STEP 4 from a fresh counter.
        apply_reset();
        send(OP_STEP, 16'd4);
        idle(6);

        // Priority among armed slots; unarmed slots are ignored.
        send(OP_SET_BP, 16'd2);
        send(OP_SET_BP, 16'd5);
        send(OP_CONTINUE, 16'd0);
        idle(2);
        step_cycle(0, 3'd0, 16'd0, 8'h80, 1);
        step_cycle(0, 3'd0, 16'd0, 8'h24, 1);
        idle(2);

        // Error responses.
        send(OP_SET_BP, 16'd9);
        send(OP_STEP, 16'd0);
        send(OP_CONTINUE, 16'd0);
        send(OP_CONTINUE, 16'd0);
        send(3'd7, 16'd0);
        send(OP_HALT, 16'd0);
        send(OP_HALT, 16'd0);

        // Backpressure on the response, then a hit racing a command.
        send(OP_SET_BP, 16'd1);
        for (int i = 0; i < 5; i++) step_cycle(1, OP_CLR_BP, 16'd1, '0, 0);
        idle(2);
        send(OP_CONTINUE, 16'd0);
        idle(1);
        step_cycle(1, OP_HALT, 16'd0, 8'h02, 1);
        idle(3);

        // Reset in the middle of a step sequence.
        send(OP_STEP, 16'd6);
        idle(3);
        apply_reset();
        send(OP_CONTINUE, 16'd0);
        for (int i = 0; i < 5; i++) step_cycle(0, 3'd0, 16'd0, '1, 1);
        send(OP_HALT, 16'd0);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) apply_reset();
            op  = 3'($urandom_range(0, 7));
            arg = (op == OP_STEP) ? 16'($urandom_range(0, 6)) : 16'($urandom_range(0, 10));
            hit = '0;
            if ($urandom_range(0, 3) == 0) begin
                hit = NUM_BP'(1) << $urandom_range(0, NUM_BP - 1);
                if ($urandom_range(0, 7) == 0) hit = hit | NUM_BP'($urandom);
            end
            step_cycle(bit'($urandom_range(0, 1)), op, arg, hit, $urandom_range(0, 3) != 0);
        end

        n = 0;
        while (sb.size() > 0 && n < 20) begin idle(1); n++; end
        @(negedge clk);
        #3;
        check("drain_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
